// File: rtl/mips_mem_loader.sv
// mips_mem_loader: framed byte-stream boot loader that writes big-endian words into IM or DM and gates the CPU
module mips_mem_loader #(
    parameter int          ADDR_W        = 16,
    parameter bit          HOLD_AT_RESET = 1'b1,
    parameter logic [7:0]  SYNC_BYTE     = 8'hA5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              im_we,
    output logic              dm_we,
    output logic              cpu_hold,
    output logic              pc_clear,
    output logic              load_done,
    output logic              load_err
);
    localparam logic [3:0] S_IDLE = 4'd0;
    localparam logic [3:0] S_TGT  = 4'd1;
    localparam logic [3:0] S_AH   = 4'd2;
    localparam logic [3:0] S_AL   = 4'd3;
    localparam logic [3:0] S_CH   = 4'd4;
    localparam logic [3:0] S_CL   = 4'd5;
    localparam logic [3:0] S_DATA = 4'd6;
    localparam logic [3:0] S_CK   = 4'd7;
    localparam logic [3:0] S_DONE = 4'd8;
    localparam logic [3:0] S_ERR  = 4'd9;

    logic [3:0]  state;
    logic        tgt_dm;
    logic [7:0]  hi_byte;
    logic [15:0] words_left;
    logic [1:0]  bcnt;
    logic [23:0] word;
    logic [7:0]  cksum;
    logic        acc;

    assign in_ready  = state != S_DONE && state != S_ERR;
    assign acc       = in_valid && in_ready;
    assign load_done = state == S_DONE;
    assign pc_clear  = state == S_DONE;

    // frame parser: header fields, word assembly, write strobes, checksum and CPU hold
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            tgt_dm     <= 1'b0;
            hi_byte    <= '0;
            words_left <= '0;
            bcnt       <= '0;
            word       <= '0;
            cksum      <= '0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            im_we      <= 1'b0;
            dm_we      <= 1'b0;
            cpu_hold   <= HOLD_AT_RESET;
            load_err   <= 1'b0;
        end else begin
            im_we <= 1'b0;
            dm_we <= 1'b0;
            // address advances once the strobe cycle has presented the current word
            if (im_we || dm_we) mem_addr <= mem_addr + ADDR_W'(4);
            case (state)
                S_IDLE: if (acc && in_data == SYNC_BYTE) begin
                    load_err <= 1'b0;
                    cksum    <= '0;
                    cpu_hold <= 1'b1;
                    state    <= S_TGT;
                end
                S_TGT: if (acc) begin
                    tgt_dm <= in_data == 8'h01;
                    state  <= (in_data == 8'h00 || in_data == 8'h01) ? S_AH : S_ERR;
                end
                S_AH: if (acc) begin
                    hi_byte <= in_data;
                    state   <= S_AL;
                end
                S_AL: if (acc) begin
                    mem_addr <= ADDR_W'({hi_byte, in_data});
                    state    <= (in_data[1:0] != 2'b00) ? S_ERR : S_CH;
                end
                S_CH: if (acc) begin
                    hi_byte <= in_data;
                    state   <= S_CL;
                end
                S_CL: if (acc) begin
                    words_left <= {hi_byte, in_data};
                    bcnt       <= '0;
                    state      <= ({hi_byte, in_data} == 16'd0) ? S_CK : S_DATA;
                end
                S_DATA: if (acc) begin
                    cksum <= cksum ^ in_data;
                    bcnt  <= bcnt + 2'd1;
                    word  <= {word[15:0], in_data};
                    if (bcnt == 2'd3) begin
                        mem_wdata  <= {word, in_data};
                        im_we      <= !tgt_dm;
                        dm_we      <= tgt_dm;
                        words_left <= words_left - 16'd1;
                        if (words_left == 16'd1) state <= S_CK;
                    end
                end
                S_CK: if (acc) state <= (in_data == cksum) ? S_DONE : S_ERR;
                S_DONE: begin
                    cpu_hold <= 1'b0;
                    state    <= S_IDLE;
                end
                S_ERR: begin
                    load_err <= 1'b1;
                    state    <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mips_mem_loader.sv
// tb_mips_mem_loader: directed frame tests for the boot loader
module tb_mips_mem_loader;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        im_we, dm_we, cpu_hold, pc_clear, load_done, load_err;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int pc_cnt = 0;
    int both_cnt = 0;
    logic [15:0] q_addr[$];
    logic [31:0] q_data[$];
    logic        q_dm[$];

    mips_mem_loader dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .im_we(im_we), .dm_we(dm_we),
        .cpu_hold(cpu_hold), .pc_clear(pc_clear), .load_done(load_done), .load_err(load_err)
    );

    always #5 clk = ~clk;

    // record every strobe and pulse away from the active edge
    always @(negedge clk) begin
        if (im_we) begin q_addr.push_back(mem_addr); q_data.push_back(mem_wdata); q_dm.push_back(1'b0); end
        if (dm_we) begin q_addr.push_back(mem_addr); q_data.push_back(mem_wdata); q_dm.push_back(1'b1); end
        if (im_we && dm_we) both_cnt++;
        if (load_done) done_cnt++;
        if (pc_clear) pc_cnt++;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, got running exp finished");
        $fatal(1);
    end

    task automatic send(input logic [7:0] b);
        int n;
        n = 0;
        in_data = b;
        in_valid = 1'b1;
        while (!in_ready && n < 20) begin @(negedge clk); n++; end
        if (!in_ready) begin
            checks++; errors++;
            $display("FAIL send_timeout: in_ready got 0 exp 1 for byte %h", b);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic send_bytes(input logic [7:0] bs[$]);
        foreach (bs[i]) send(bs[i]);
    endtask

    task automatic test_reset;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready: got %b exp 1", in_ready); end
        checks++; if (cpu_hold !== 1'b1) begin errors++; $display("FAIL rst_cpu_hold: got %b exp 1", cpu_hold); end
        checks++; if ({im_we, dm_we, pc_clear, load_done, load_err} !== 5'b0) begin errors++; $display("FAIL rst_pulses: got %b exp 00000", {im_we, dm_we, pc_clear, load_done, load_err}); end
        checks++; if ({mem_addr, mem_wdata} !== 48'h0) begin errors++; $display("FAIL rst_mem_bus: got %h exp 0", {mem_addr, mem_wdata}); end
    endtask

    task automatic test_im_load;
        logic [7:0] f[$];
        int b, d;
        b = q_addr.size(); d = done_cnt;
        f = {8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h20, 8'h09, 8'h00, 8'h0A, 8'h0E};
        send_bytes(f);
        checks++; if ({load_done, pc_clear, in_ready, cpu_hold} !== 4'b1101) begin errors++; $display("FAIL im_done_cycle: got %b exp 1101", {load_done, pc_clear, in_ready, cpu_hold}); end
        @(negedge clk);
        checks++; if ({load_done, pc_clear, cpu_hold} !== 3'b000) begin errors++; $display("FAIL im_after_done: got %b exp 000", {load_done, pc_clear, cpu_hold}); end
        checks++; if (q_addr.size() - b !== 2) begin errors++; $display("FAIL im_write_count: got %0d exp 2", q_addr.size() - b); end
        else begin
            checks++; if ({q_dm[b], q_addr[b], q_data[b]} !== {1'b0, 16'h0000, 32'h20080005}) begin errors++; $display("FAIL im_word0: got %b %h %h exp 0 0000 20080005", q_dm[b], q_addr[b], q_data[b]); end
            checks++; if ({q_dm[b+1], q_addr[b+1], q_data[b+1]} !== {1'b0, 16'h0004, 32'h2009000A}) begin errors++; $display("FAIL im_word1: got %b %h %h exp 0 0004 2009000a", q_dm[b+1], q_addr[b+1], q_data[b+1]); end
        end
        checks++; if (done_cnt - d !== 1) begin errors++; $display("FAIL im_done_count: got %0d exp 1", done_cnt - d); end
    endtask

    task automatic test_dm_load;
        logic [7:0] f[$];
        int b, d;
        b = q_addr.size(); d = done_cnt;
        f = {8'hA5, 8'h01, 8'h00, 8'h08, 8'h00, 8'h01, 8'hDE, 8'hAD};
        send_bytes(f);
        repeat (3) @(negedge clk);
        f = {8'hBE, 8'hEF, 8'h22};
        send_bytes(f);
        @(negedge clk);
        checks++; if (q_addr.size() - b !== 1) begin errors++; $display("FAIL dm_write_count: got %0d exp 1", q_addr.size() - b); end
        else begin
            checks++; if ({q_dm[b], q_addr[b], q_data[b]} !== {1'b1, 16'h0008, 32'hDEADBEEF}) begin errors++; $display("FAIL dm_word: got %b %h %h exp 1 0008 deadbeef", q_dm[b], q_addr[b], q_data[b]); end
        end
        checks++; if (done_cnt - d !== 1) begin errors++; $display("FAIL dm_done_count: got %0d exp 1", done_cnt - d); end
    endtask

    task automatic test_bad_cksum;
        logic [7:0] f[$];
        int b, d;
        b = q_addr.size(); d = done_cnt;
        f = {8'hA5, 8'h01, 8'h00, 8'h08, 8'h00, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h00};
        send_bytes(f);
        checks++; if ({in_ready, load_done} !== 2'b00) begin errors++; $display("FAIL ck_err_cycle: got %b exp 00", {in_ready, load_done}); end
        @(negedge clk);
        checks++; if ({load_err, cpu_hold} !== 2'b11) begin errors++; $display("FAIL ck_err_flags: got %b exp 11", {load_err, cpu_hold}); end
        repeat (3) @(negedge clk);
        checks++; if ({load_err, cpu_hold} !== 2'b11) begin errors++; $display("FAIL ck_err_sticky: got %b exp 11", {load_err, cpu_hold}); end
        checks++; if (q_addr.size() - b !== 1 || done_cnt != d) begin errors++; $display("FAIL ck_writes_done: got %0d/%0d exp 1/0", q_addr.size() - b, done_cnt - d); end
        send(8'hA5);
        checks++; if (load_err !== 1'b0) begin errors++; $display("FAIL ck_err_clear: got %b exp 0", load_err); end
        f = {8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        send_bytes(f);
        @(negedge clk);
        checks++; if (done_cnt - d !== 1) begin errors++; $display("FAIL ck_recover_done: got %0d exp 1", done_cnt - d); end
    endtask

    task automatic test_unaligned;
        logic [7:0] f[$];
        int b, d;
        b = q_addr.size(); d = done_cnt;
        f = {8'hA5, 8'h00, 8'h00, 8'h02};
        send_bytes(f);
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL ua_err_cycle: in_ready got %b exp 0", in_ready); end
        f = {8'h00, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44, 8'h10};
        send_bytes(f);
        repeat (2) @(negedge clk);
        checks++; if ({load_err, cpu_hold} !== 2'b11) begin errors++; $display("FAIL ua_flags: got %b exp 11", {load_err, cpu_hold}); end
        checks++; if (q_addr.size() - b !== 0 || done_cnt != d) begin errors++; $display("FAIL ua_no_writes: got %0d/%0d exp 0/0", q_addr.size() - b, done_cnt - d); end
    endtask

    task automatic test_garbage_zero;
        logic [7:0] f[$];
        int b, d;
        b = q_addr.size(); d = done_cnt;
        f = {8'h00, 8'hFF, 8'h13, 8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        send_bytes(f);
        repeat (2) @(negedge clk);
        checks++; if (done_cnt - d !== 1) begin errors++; $display("FAIL zc_done: got %0d exp 1", done_cnt - d); end
        checks++; if (q_addr.size() - b !== 0) begin errors++; $display("FAIL zc_writes: got %0d exp 0", q_addr.size() - b); end
        checks++; if ({load_err, cpu_hold} !== 2'b00) begin errors++; $display("FAIL zc_flags: got %b exp 00", {load_err, cpu_hold}); end
    endtask

    task automatic test_wrap;
        logic [7:0] f[$];
        int b;
        b = q_addr.size();
        f = {8'hA5, 8'h00, 8'hFF, 8'hFC, 8'h00, 8'h02, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h08};
        send_bytes(f);
        @(negedge clk);
        checks++; if (q_addr.size() - b !== 2) begin errors++; $display("FAIL wrap_count: got %0d exp 2", q_addr.size() - b); end
        else begin
            checks++; if ({q_addr[b], q_data[b]} !== {16'hFFFC, 32'h01020304}) begin errors++; $display("FAIL wrap_word0: got %h %h exp fffc 01020304", q_addr[b], q_data[b]); end
            checks++; if ({q_addr[b+1], q_data[b+1]} !== {16'h0000, 32'h05060708}) begin errors++; $display("FAIL wrap_word1: got %h %h exp 0000 05060708", q_addr[b+1], q_data[b+1]); end
        end
        checks++; if (load_err !== 1'b0) begin errors++; $display("FAIL wrap_err: got %b exp 0", load_err); end
    endtask

    task automatic test_reset_mid;
        logic [7:0] f[$];
        int b, d;
        b = q_addr.size();
        f = {8'hA5, 8'h00, 8'h00, 8'h10, 8'h00, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        send_bytes(f);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        checks++; if ({cpu_hold, in_ready, im_we, dm_we, load_done} !== 5'b11000) begin errors++; $display("FAIL rm_reset_state: got %b exp 11000", {cpu_hold, in_ready, im_we, dm_we, load_done}); end
        checks++; if (q_addr.size() - b !== 1) begin errors++; $display("FAIL rm_write_count: got %0d exp 1", q_addr.size() - b); end
        else begin
            checks++; if ({q_addr[b], q_data[b]} !== {16'h0010, 32'h11223344}) begin errors++; $display("FAIL rm_word: got %h %h exp 0010 11223344", q_addr[b], q_data[b]); end
        end
        rst_n = 1'b1;
        @(negedge clk);
        b = q_addr.size(); d = done_cnt;
        f = {8'hA5, 8'h00, 8'h00, 8'h20, 8'h00, 8'h01, 8'hCA, 8'hFE, 8'hBA, 8'hBE, 8'h30};
        send_bytes(f);
        @(negedge clk);
        checks++; if (q_addr.size() - b !== 1) begin errors++; $display("FAIL rm_reload_count: got %0d exp 1", q_addr.size() - b); end
        else begin
            checks++; if ({q_dm[b], q_addr[b], q_data[b]} !== {1'b0, 16'h0020, 32'hCAFEBABE}) begin errors++; $display("FAIL rm_reload_word: got %b %h %h exp 0 0020 cafebabe", q_dm[b], q_addr[b], q_data[b]); end
        end
        checks++; if (done_cnt - d !== 1 || cpu_hold !== 1'b0) begin errors++; $display("FAIL rm_reload_done: got %0d/%b exp 1/0", done_cnt - d, cpu_hold); end
    endtask

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0;
        in_data = 8'h00;
        repeat (2) @(negedge clk);
        test_reset;
        rst_n = 1'b1;
        @(negedge clk);
        test_im_load;
        test_dm_load;
        test_bad_cksum;
        test_unaligned;
        test_garbage_zero;
        test_wrap;
        test_reset_mid;
        checks++; if (both_cnt !== 0) begin errors++; $display("FAIL dual_strobe: got %0d exp 0", both_cnt); end
        checks++; if (pc_cnt !== done_cnt) begin errors++; $display("FAIL pc_clear_count: got %0d exp %0d", pc_cnt, done_cnt); end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
